uart_transmitter: RTL and testbench
===================================

// Module: uart_transmitter
// PURPOSE
//  Serialises one parallel byte into an asynchronous UART frame on the TX line.
//  Frame order: start bit, then LSB-first data, then optional parity, then stop bit(s).
//  The bit period is generated internally by a clock-divider counter.
//  Upstream stage of the UART link: TX drives the RX input of the far-end UART receiver.
//  Driven by system control logic through a START/BUSY/DONE handshake.
// PARAMETERS
//  CLKS_PER_BIT  434  clc cycles per bit period (50 MHz / 115200); legal range >= 2
//  DATA_BITS     8    data bits per frame; legal range 5..8
//  PARITY        0    0 = none, 1 = even, 2 = odd
//  STOP_BITS     1    stop bits per frame; legal values 1 or 2
// PORTS
//  clc    in   1          system clock, all logic on the rising edge
//  res    in   1          reset, asynchronous, active-high
//  START  in   1          transmit request, sampled only while BUSY=0
//  DATA   in   DATA_BITS  byte to send, sampled on the same edge START is accepted
//  TX     out  1          serial line output, idles high
//  BUSY   out  1          high from the accept edge until the frame ends
//  DONE   out  1          one-cycle pulse after the last stop bit completes
// BEHAVIOUR
//  Reset (res=1, asynchronous): TX=1, BUSY=0, DONE=0, state=IDLE, counters=0, shift reg=0.
//  Any in-flight frame is abandoned on reset; no DONE is produced for it.
//  All outputs are registered; there is no combinational path from inputs to outputs.
//  FSM states: IDLE -> START_B -> DATA_B -> [PARITY_B] -> STOP_B -> IDLE.
//   IDLE:     TX=1, BUSY=0. On an edge with START=1:
//             latch DATA into the shift register, compute parity, clear the bit timer, enter START_B.
//   START_B:  TX=0 for exactly CLKS_PER_BIT cycles.
//   DATA_B:   TX=shift[0] for CLKS_PER_BIT cycles per bit; shift right between bits.
//             Leaves after DATA_BITS bits.
//   PARITY_B: present only if PARITY!=0.
//             TX = XOR of the data bits (even) or its complement (odd); lasts CLKS_PER_BIT cycles.
//   STOP_B:   TX=1 for STOP_BITS*CLKS_PER_BIT cycles.
//             On the final cycle: next state IDLE, BUSY->0, DONE->1 for exactly one cycle.
//  Bit timer: counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT); wraps to 0 at each bit boundary.
//  Timing: if START is accepted at edge k, then TX=0 and BUSY=1 from edge k.
//  Total frame = (1+DATA_BITS+(PARITY?1:0)+STOP_BITS)*CLKS_PER_BIT cycles; BUSY=1 for all of them.
//  The DONE cycle is also IDLE: a START present in that cycle is accepted on the next edge.
//  Minimum gap between frames is therefore one idle clock, with TX=1.
//  START while BUSY=1 is ignored, not queued. DATA changes while BUSY=1 have no effect.
//  START held high continuously: frames are sent back to back, each separated by the one-cycle DONE gap.
//  Unused upper DATA bits (when DATA_BITS<8): the port is exactly DATA_BITS wide, so no masking is needed.
// TESTING (bench default CLKS_PER_BIT=4 unless noted)
//  1 Reset then idle 20 cycles -> TX=1, BUSY=0, DONE=0 throughout.
//  2 DATA=8'hA5, START pulse 1 cycle, PARITY=0 -> TX sequence 0,1,0,1,0,0,1,0,1,1.
//    Each level is held 4 cycles; BUSY high for 40 cycles; DONE pulses exactly once at cycle 40.
//  3 PARITY=1, DATA=8'h07 -> parity bit=1.
//    PARITY=2, same data -> parity bit=0. Frame length 44 cycles.
//  4 Second START (DATA=8'hFF) pulsed mid-frame of 8'h3C -> ignored.
//    Only 8'h3C is sent; exactly one DONE is produced.
//  5 START held high with DATA=8'h55 -> consecutive frames.
//    Each DONE is followed by the next start bit one cycle later; TX=1 in the gap cycle.
//  6 Assert res during data bit 3 -> TX=1 and BUSY=0 immediately (asynchronous), no DONE.
//    After release, a new START sends a clean, complete frame.

Source files
------------

// File: rtl/uart_transmitter.sv
// UART transmitter: serialises a DATA_BITS word into start, LSB-first data, optional parity
// and stop bits, with the bit period derived from an internal clock-divider counter.
module uart_transmitter #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                 clc,
   input  logic                 res,
   input  logic                 START,
   input  logic [DATA_BITS-1:0] DATA,
   output logic                 TX,
   output logic                 BUSY,
   output logic                 DONE
);

   localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned IdxW = $clog2(DATA_BITS);
   localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
   localparam logic [IdxW-1:0] IdxMax = IdxW'(DATA_BITS - 1);
   localparam logic            StopLast = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e               state_q, state_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [IdxW-1:0]      idx_q, idx_d;
   logic                 stop_q, stop_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 bit_end;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      stop_d  = stop_q;
      shift_d = shift_q;
      par_d   = par_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      bit_end = (cnt_q == CntMax);

      if (state_q != StIdle) begin
         cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
      end

      unique case (state_q)
         StIdle: begin
            if (START) begin
               shift_d = DATA;
               par_d   = (PARITY == 2) ? ~(^DATA) : ^DATA;
               cnt_d   = '0;
               idx_d   = '0;
               stop_d  = 1'b0;
               busy_d  = 1'b1;
               state_d = StStart;
            end
         end
         StStart: begin
            if (bit_end) state_d = StData;
         end
         StData: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (idx_q == IdxMax) begin
                  state_d = (PARITY != 0) ? StParity : StStop;
               end else begin
                  idx_d = idx_q + IdxW'(1);
               end
            end
         end
         StParity: begin
            if (bit_end) state_d = StStop;
         end
         StStop: begin
            if (bit_end) begin
               if (stop_q == StopLast) begin
                  state_d = StIdle;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  stop_d = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // TX is registered from the next state so the line changes on the same edge as the state.
      unique case (state_d)
         StStart:  tx_d = 1'b0;
         StData:   tx_d = shift_d[0];
         StParity: tx_d = par_d;
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clc or posedge res) begin
      if (res) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= '0;
         stop_q  <= 1'b0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         stop_q  <= stop_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign TX   = tx_q;
   assign BUSY = busy_q;
   assign DONE = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench: stimulus pushes expected frames, a negedge monitor rebuilds each frame
// from TX while BUSY is high and compares on DONE.
module tb_uart_transmitter;

   typedef struct {
      logic [15:0] seq;
      int          nbits;
   } exp_t;

   logic       clc = 1'b0;
   logic       res = 1'b0;
   logic       start0 = 1'b0;
   logic [7:0] data0 = 8'h00;
   logic       start12 = 1'b0;
   logic [7:0] data12 = 8'h00;
   logic       tx0, busy0, done0;
   logic       tx1, busy1, done1;
   logic       tx2, busy2, done2;

   int checks = 0;
   int errors = 0;

   exp_t        q0[$];
   exp_t        q1[$];
   exp_t        q2[$];
   int          cyc[3];
   logic [15:0] got[3];
   bit          glitch[3];

   always #5 clc = ~clc;

   uart_transmitter #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
      .clc(clc), .res(res), .START(start0), .DATA(data0), .TX(tx0), .BUSY(busy0), .DONE(done0)
   );
   uart_transmitter #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_dut1 (
      .clc(clc), .res(res), .START(start12), .DATA(data12), .TX(tx1), .BUSY(busy1), .DONE(done1)
   );
   uart_transmitter #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut2 (
      .clc(clc), .res(res), .START(start12), .DATA(data12), .TX(tx2), .BUSY(busy2), .DONE(done2)
   );

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic push(input int ch, input logic [15:0] seq, input int nbits);
      exp_t e;
      e.seq   = seq;
      e.nbits = nbits;
      case (ch)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic mon(input int ch, input logic tx, input logic busy, input logic done);
      exp_t        e;
      bit          have;
      logic [15:0] mask;
      if (done) begin
         chk($sformatf("ch%0d done_cycle_busy_tx", ch), int'({busy, tx}), 1);
         have = 1'b0;
         case (ch)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
         endcase
         chk($sformatf("ch%0d done_expected", ch), int'(have), 1);
         if (have) begin
            mask = (16'h1 << e.nbits) - 16'h1;
            chk($sformatf("ch%0d frame_len", ch), cyc[ch], e.nbits * 4);
            chk($sformatf("ch%0d frame_bits", ch), int'(got[ch] & mask), int'(e.seq & mask));
            chk($sformatf("ch%0d bit_hold", ch), int'(glitch[ch]), 0);
         end
         cyc[ch] = 0; got[ch] = '0; glitch[ch] = 1'b0;
      end else if (busy) begin
         if (cyc[ch] < 64) begin
            if (cyc[ch] % 4 == 0) got[ch][cyc[ch] / 4] = tx;
            else if (tx !== got[ch][cyc[ch] / 4]) glitch[ch] = 1'b1;
         end
         cyc[ch]++;
      end else begin
         chk($sformatf("ch%0d idle_tx", ch), int'(tx === 1'b1), 1);
         cyc[ch] = 0; got[ch] = '0; glitch[ch] = 1'b0;
      end
   endtask

   always @(negedge clc) begin
      mon(0, tx0, busy0, done0);
      mon(1, tx1, busy1, done1);
      mon(2, tx2, busy2, done2);
   end

   function automatic logic cur_done(input int ch);
      case (ch)
         0:       return done0;
         1:       return done1;
         default: return done2;
      endcase
   endfunction

   task automatic wait_done(input int ch, input string nm);
      int n;
      n = 0;
      while (cur_done(ch) !== 1'b1 && n < 100) begin
         @(negedge clc);
         n++;
      end
      chk(nm, int'(cur_done(ch) === 1'b1), 1);
   endtask

   task automatic pulse0(input logic [7:0] d);
      @(negedge clc);
      start0 = 1'b1;
      data0  = d;
      @(negedge clc);
      start0 = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         cyc[i] = 0; got[i] = '0; glitch[i] = 1'b0;
      end
      #1 res = 1'b1;
      repeat (3) @(negedge clc);
      chk("reset_tx", int'({tx0, tx1, tx2}), 7);
      chk("reset_busy", int'({busy0, busy1, busy2}), 0);
      chk("reset_done", int'({done0, done1, done2}), 0);
      res = 1'b0;
      repeat (20) @(negedge clc);

      // Frame {stop, A5, start}, no parity.
      push(0, 16'b11_0100_1010, 10);
      pulse0(8'hA5);
      chk("accept_latency", int'({busy0, tx0}), 2);
      wait_done(0, "a5_done");
      repeat (5) @(negedge clc);

      // 8'h07 carries three ones: even parity bit 1, odd parity bit 0.
      push(1, 16'b110_0000_1110, 11);
      push(2, 16'b100_0000_1110, 11);
      @(negedge clc);
      start12 = 1'b1;
      data12  = 8'h07;
      @(negedge clc);
      start12 = 1'b0;
      data12  = 8'h00;
      wait_done(1, "even_done");
      chk("odd_done_same_cycle", int'(done2), 1);
      repeat (5) @(negedge clc);

      // Second request mid-frame must be dropped.
      push(0, 16'b10_0111_1000, 10);
      pulse0(8'h3C);
      repeat (10) @(negedge clc);
      start0 = 1'b1;
      data0  = 8'hFF;
      @(negedge clc);
      start0 = 1'b0;
      wait_done(0, "3c_done");
      repeat (50) @(negedge clc);

      // START held high: back-to-back frames with a single idle gap.
      for (int i = 0; i < 3; i++) push(0, 16'b10_1010_1010, 10);
      @(negedge clc);
      start0 = 1'b1;
      data0  = 8'h55;
      wait_done(0, "b2b_done1");
      @(negedge clc);
      chk("b2b_restart1", int'({busy0, tx0}), 2);
      wait_done(0, "b2b_done2");
      @(negedge clc);
      chk("b2b_restart2", int'({busy0, tx0}), 2);
      start0 = 1'b0;
      wait_done(0, "b2b_done3");
      @(negedge clc);
      chk("b2b_stop_after_third", int'({busy0, tx0}), 1);
      repeat (5) @(negedge clc);

      // Asynchronous reset during data bit 3 abandons the frame silently.
      pulse0(8'hA5);
      repeat (17) @(negedge clc);
      #1 res = 1'b1;
      #1;
      chk("async_reset_tx_busy", int'({tx0, busy0}), 2);
      chk("async_reset_done", int'(done0), 0);
      repeat (2) @(negedge clc);
      res = 1'b0;
      repeat (10) @(negedge clc);
      push(0, 16'b11_0100_1010, 10);
      pulse0(8'hA5);
      wait_done(0, "post_reset_done");
      repeat (5) @(negedge clc);

      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      chk("q2_drained", q2.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
